// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM states and coin codes.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      DISPENSE = 2'b01,
      REFUND   = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      COIN_NONE     = 2'b00,
      COIN_CIRCLE   = 2'b01,
      COIN_TRIANGLE = 2'b10,
      COIN_PENTAGON = 2'b11
   } coin_e;

endpackage

// File: rtl/param_vending_fsm_if.sv
// Vending controller bus: coin acceptor / refund button / dispenser side.
// master: drives coin, refund, drop_ack; slave (the controller) drives
// credit, drop, change, coin_reject.
interface param_vending_fsm_if #(
   parameter int unsigned CREDIT_W = 4
);
   logic [1:0]          coin;
   logic                refund;
   logic                drop_ack;
   logic [CREDIT_W-1:0] credit;
   logic                drop;
   logic                change;
   logic                coin_reject;

   modport master (
      output coin, refund, drop_ack,
      input  credit, drop, change, coin_reject
   );

   modport slave (
      input  coin, refund, drop_ack,
      output credit, drop, change, coin_reject
   );
endinterface

// File: rtl/vend_credit_reg.sv
// Credit holding register with synchronous active-low clear and load enable.
// Ports: i_clock, i_reset_n (sync clear), i_load, i_d -> o_q.
module vend_credit_reg #(
   parameter int unsigned CREDIT_W = 4
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic                i_load,
   input  logic [CREDIT_W-1:0] i_d,
   output logic [CREDIT_W-1:0] o_q
);

   logic [CREDIT_W-1:0] r_q;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/param_vending_fsm.sv
// Coin-operated vending controller: accumulates credit, dispenses one item
// per PRICE with a drop handshake, rejects overflowing coins, refunds
// leftover credit one unit per cycle.
// Ports: clock, reset_n (sync, active-low), bus (slave side: coin, refund,
// drop_ack in; credit, drop, change, coin_reject out).
module param_vending_fsm
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W     = 4,
   parameter int unsigned PRICE        = 4,
   parameter int unsigned VAL_CIRCLE   = 1,
   parameter int unsigned VAL_TRIANGLE = 3,
   parameter int unsigned VAL_PENTAGON = 5
) (
   input  logic                 clock,
   input  logic                 reset_n,
   param_vending_fsm_if.slave   bus
);

   localparam int unsigned SUM_W      = CREDIT_W + 1;
   localparam int unsigned MAX_CREDIT = (1 << CREDIT_W) - 1;

   if (PRICE == 0 || PRICE > MAX_CREDIT || VAL_CIRCLE > MAX_CREDIT ||
       VAL_TRIANGLE > MAX_CREDIT || VAL_PENTAGON > MAX_CREDIT) begin : g_param_check
      $error("param_vending_fsm: PRICE must be 1..2**CREDIT_W-1 and coin values <= 2**CREDIT_W-1");
   end

   state_e              r_state;
   state_e              w_state_next;
   logic                r_coin_reject;
   logic                w_coin_reject_next;
   logic [CREDIT_W-1:0] w_credit;
   logic [CREDIT_W-1:0] w_credit_next;
   logic                w_credit_load;
   logic [SUM_W-1:0]    w_cur;
   logic [SUM_W-1:0]    w_coin_val;
   logic [SUM_W-1:0]    w_base;
   logic [SUM_W-1:0]    w_sum;
   logic                w_coin_ok;
   logic                w_refund_go;
   logic                w_can_buy;

   assign w_cur       = {1'b0, w_credit};
   assign w_refund_go = bus.refund && (w_credit != '0);
   assign w_can_buy   = (w_cur >= SUM_W'(PRICE));

   // Coin code to credit value.
   always_comb begin
      w_coin_val = '0;
      case (bus.coin)
         COIN_CIRCLE:   w_coin_val = SUM_W'(VAL_CIRCLE);
         COIN_TRIANGLE: w_coin_val = SUM_W'(VAL_TRIANGLE);
         COIN_PENTAGON: w_coin_val = SUM_W'(VAL_PENTAGON);
         default:       w_coin_val = '0;
      endcase
   end

   // State register and registered reject flag.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_coin_reject <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_coin_reject <= w_coin_reject_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_refund_go) begin
               w_state_next = REFUND;
            end else if (w_can_buy) begin
               w_state_next = DISPENSE;
            end
         end
         DISPENSE: begin
            if (bus.drop_ack) begin
               w_state_next = IDLE;
            end
         end
         REFUND: begin
            // Leave on the edge that takes credit from 1 to 0.
            if (w_credit <= CREDIT_W'(1)) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Next-credit logic: pick a base, then credit the coin only if it fits.
   always_comb begin
      w_base    = w_cur;
      w_coin_ok = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_refund_go) begin
               w_base    = w_cur;
               w_coin_ok = 1'b0;
            end else begin
               w_base    = w_can_buy ? (w_cur - SUM_W'(PRICE)) : w_cur;
               w_coin_ok = 1'b1;
            end
         end
         DISPENSE: begin
            w_base    = w_cur;
            w_coin_ok = 1'b1;
         end
         REFUND: begin
            w_base    = (w_cur != '0) ? (w_cur - SUM_W'(1)) : '0;
            w_coin_ok = 1'b0;
         end
         default: begin
            w_base    = '0;
            w_coin_ok = 1'b0;
         end
      endcase

      w_sum = w_base + w_coin_val;
      if (w_coin_ok && (w_sum > SUM_W'(MAX_CREDIT))) begin
         w_coin_ok = 1'b0;
      end

      w_credit_next      = w_coin_ok ? CREDIT_W'(w_sum) : CREDIT_W'(w_base);
      w_credit_load      = (w_credit_next != w_credit);
      w_coin_reject_next = (bus.coin != COIN_NONE) && !w_coin_ok;
   end

   vend_credit_reg #(
      .CREDIT_W (CREDIT_W)
   ) u_credit (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_load    (w_credit_load),
      .i_d       (w_credit_next),
      .o_q       (w_credit)
   );

   assign bus.credit      = w_credit;
   assign bus.drop        = (r_state == DISPENSE);
   assign bus.change      = (r_state == REFUND);
   assign bus.coin_reject = r_coin_reject;

endmodule

// File: doc/param_vending_fsm.md
Name: param_vending_fsm

Overview:
Parametrised coin-operated vending controller. It accumulates coin credit, dispenses one item per PRICE of credit, and waits for a mechanical drop acknowledge before each item completes. It also rejects coins that would overflow the credit register and refunds leftover credit one unit per cycle on request. It sits between the coin acceptor / refund button and the dispenser mechanism.

Parameters:
CREDIT_W, 4, width of credit register; maximum credit is 2**CREDIT_W-1
PRICE, 4, item price in credit units; legal range 1 to 2**CREDIT_W-1
VAL_CIRCLE, 1, credit value of coin code 2'b01
VAL_TRIANGLE, 3, credit value of coin code 2'b10
VAL_PENTAGON, 5, credit value of coin code 2'b11; every coin value must be at most 2**CREDIT_W-1

Ports:
clock  input  1  single system clock; all state changes on its rising edge
reset_n  input  1  reset, synchronous and active-low
coin  input  2  coin inserted this cycle: 00 none, 01 circle, 10 triangle, 11 pentagon; at most one coin per cycle
refund  input  1  refund request, sampled each cycle
drop_ack  input  1  dispenser has released the item
credit  output  CREDIT_W  current credit (registered)
drop  output  1  dispense request; held until acknowledged
change  output  1  one credit unit returned this cycle
coin_reject  output  1  coin from the previous cycle was returned, not credited

Behaviour:
- Reset: reset_n=0 at a rising edge forces the following, from any state including mid-dispense or mid-refund:
  - state=IDLE, credit=0, coin_reject=0
  - drop and change deassert in the cycle after that edge
- States: IDLE, DISPENSE, REFUND. Outputs are Moore:
  - drop = (state==DISPENSE)
  - change = (state==REFUND)
- Coin value v = 0 for code 00. All arithmetic is done at CREDIT_W+1 bits, with no silent wrap.
- IDLE, evaluated in this priority:
  - refund=1 and credit!=0: go to REFUND; credit unchanged; any coin this cycle is rejected.
  - credit>=PRICE: go to DISPENSE; base = credit-PRICE.
  - Otherwise stay in IDLE; base = credit.
  - Coin accepted iff base+v <= 2**CREDIT_W-1; then credit_next = base+v, else credit_next = base.
  - refund with credit==0 is ignored.
- DISPENSE:
  - drop=1. Coins are accepted with base = credit, using the same overflow rule.
  - refund is ignored.
  - drop_ack=1: go to IDLE.
  - Remaining credit >= PRICE re-triggers DISPENSE one cycle later via IDLE, so there is one idle cycle between consecutive drops.
  - drop_ack in any other state is ignored.
- REFUND:
  - change=1 every cycle, credit decrements by 1 each edge.
  - The edge at which credit goes 1->0 returns the FSM to IDLE.
  - Number of change pulses equals the credit on entry.
  - All nonzero coins are rejected; refund is ignored.
- coin_reject: registered. It is 1 in the cycle after any edge at which a nonzero coin was not credited, otherwise 0.
- Latency: a coin is reflected in credit 1 cycle after the edge at which it is sampled. drop rises no earlier than 1 cycle after credit>=PRICE is visible.
- Parameter violations (PRICE=0, PRICE or a coin value > 2**CREDIT_W-1) are flagged by an elaboration-time assertion.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, DISPENSE, REFUND)
  - coin code enum (COIN_NONE, COIN_CIRCLE, COIN_TRIANGLE, COIN_PENTAGON)
- Sub-module vend_credit_reg:
  - CREDIT_W-wide register with synchronous active-low clear and load enable.
  - Holds credit; the next-credit arithmetic stays in the parent.
- Next-state logic and next-credit logic are separate combinational blocks.

Test Plan:
- Defaults; reset_n=0 for 2 cycles while coin=11 -> credit=0, drop=0, change=0, coin_reject=0.
- Dispense: coins 10,10 on consecutive edges -> credit 3 then 6. Next edge -> drop=1, credit=2. drop_ack held 3 cycles later -> drop=0 next cycle, credit=2, state IDLE.
- Overflow: coins 11,11 (edge 2 starts DISPENSE, credit=6), then in DISPENSE coins 11,10,10 with drop_ack=0 -> credit 11, 14, then 14 unchanged. coin_reject=1 the cycle after the third coin.
- Refund:
  - Credit=3 in IDLE, refund=1 with coin=01 -> coin_reject=1, then change=1 for exactly 3 cycles with credit 3,2,1, then credit=0, IDLE.
  - refund at credit=0 -> no change pulse.
- Back-to-back: credit=8, drop_ack pulsed each time drop=1 -> two drops separated by one drop=0 cycle, final credit=0.
- Reset mid-operation: reset_n=0 during DISPENSE (credit=5) and during REFUND -> next cycle drop=0, change=0, credit=0. PRICE=7, CREDIT_W=5 variant: coins 11,10 -> credit 8, then drop=1 with credit=1.
